mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the MIPS datapath. It handles the MULT/MULTU/DIV/DIVU family that the single-cycle ALU does not. It accepts operands from the execute stage through a start/busy/done handshake, computes over multiple cycles, and holds the architectural HI/LO registers read by MFHI/MFLO. MTHI/MTLO writes complete in one cycle.

## Interface
- WORD_W, 32, operand/result width; counter width is $clog2(WORD_W)+1.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- start  in  1  issue request; sampled only while busy=0.
- op  in  3  3'b000 MULT, 3'b001 MULTU, 3'b010 DIV, 3'b011 DIVU, 3'b100 MTHI, 3'b101 MTLO; others are no-op.
- a  in  WORD_W  rs operand (dividend / multiplicand / MT source).
- b  in  WORD_W  rt operand (divisor / multiplier).
- flush  in  1  synchronous abort of in-flight op.
- busy  out  1  operation in progress; HI/LO not valid to read.
- done  out  1  one-cycle pulse; HI/LO just updated by mult/div.
- hi  out  WORD_W  HI register.
- lo  out  WORD_W  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - latch the operands as magnitudes (abs value when signed op and MSB=1);
  - record result sign, remainder sign and op;
  - count=WORD_W; go to RUN.
- IDLE, start=1, op MTHI/MTLO: hi<=a or lo<=a at that edge; stay IDLE; no busy, no done.
- IDLE, start=1, undefined op: ignored.
- RUN multiply (shift-add, radix-2): if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WORD_W accumulator, then shift right 1. Decrement count; at count==1 go to FIX.
- RUN divide (restoring): shift {rem,quot} left 1, trial-subtract the divisor from rem. If non-negative, keep it and set quot LSB=1. Same counting.
- FIX:
  - mult: negate the 64-bit product if the sign flag is set; hi<=product[63:32], lo<=product[31:0].
  - div: lo<=quotient (negated if operand signs differ), hi<=remainder (negated if dividend negative).
  - assert done; go to IDLE.
- Divide by zero (b==0, DIV or DIVU): lo<=32'hFFFF_FFFF, hi<=a unmodified. The unit still takes the full latency.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo<=32'h8000_0000, hi<=0. This must fall out of the magnitude datapath with no special case.
- Signed quotient truncates toward zero. The remainder carries the sign of the dividend.
- flush=1 in RUN or FIX: go to IDLE next edge; hi/lo unchanged; no done.
- flush=1 in IDLE has priority over start: the request is dropped, including MTHI/MTLO.
- start while busy=1: ignored; operands not resampled.

## Timing
- Reset (nRST low, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, count=0, internal datapath regs 0.
- Mult/div accept at edge E0. busy=1 from E0 through the cycle before E(WORD_W+1).
- RUN occupies WORD_W cycles; FIX occupies 1 cycle. hi/lo update at edge E(WORD_W+1).
- done is registered: high for exactly the one cycle after E(WORD_W+1), with busy=0 in that cycle.
- Total latency is 33 cycles from accept to HI/LO valid. A new start is accepted in the same cycle done is high.
- MTHI/MTLO: hi/lo visible the cycle after the accepting edge; busy stays 0.
- nRST asserted mid-operation: immediate return to the reset values. No done pulse, even if the deassertion coincides with the FIX state.
- busy, done, hi and lo are driven from flops only; no combinational path from inputs.

## Test plan
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> after 33 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses once, busy low that cycle.
- MULT a=-7 (32'hFFFF_FFF9), b=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0. DIVU a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5.
- Start MULTU 6*7, pulse flush at cycle 10 -> busy drops next cycle, no done, hi/lo keep the prior values. A second start raised during busy is ignored.
- MTHI a=32'hDEAD_BEEF then MTLO a=32'h1234_5678 on back-to-back cycles -> hi/lo update one cycle each, busy never asserts. Assert nRST during a DIV -> hi=lo=0 and busy=0 immediately.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// It uses radix-2 shift-add multiply and restoring divide on operand magnitudes.
module mul_div_unit #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam int CNT_W = $clog2(WORD_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]    count;
    logic [2*WORD_W-1:0] acc;
    logic [WORD_W-1:0]   opnd;
    logic                is_div;
    logic                res_neg;
    logic                rem_neg;

    logic              req_md;
    logic              req_mthi;
    logic              req_mtlo;
    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic [WORD_W-1:0] a_mag;
    logic [WORD_W-1:0] b_mag;

    always_comb begin
        req_md   = 1'b0;
        req_mthi = 1'b0;
        req_mtlo = 1'b0;
        if (start && !flush) begin
            unique case (1'b1)
                (op[2:1] == 2'b00): req_md = 1'b1;
                (op[2:1] == 2'b01): req_md = 1'b1;
                (op == 3'b100):     req_mthi = 1'b1;
                (op == 3'b101):     req_mtlo = 1'b1;
                default: ;
            endcase
        end
    end

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WORD_W-1];
    assign b_neg     = signed_op & b[WORD_W-1];
    assign b_zero    = (b == '0);
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One iteration of either algorithm; acc is {rem,quot} when dividing.
    logic [WORD_W:0]     mul_sum;
    logic [WORD_W:0]     div_shift;
    logic [WORD_W:0]     div_diff;
    logic [2*WORD_W-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WORD_W-1:WORD_W]}
                  + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WORD_W-1:WORD_W], acc[WORD_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!is_div)
            step_acc = {mul_sum, acc[WORD_W-1:1]};
        else if (div_diff[WORD_W])
            step_acc = {div_shift[WORD_W-1:0], acc[WORD_W-2:0], 1'b0};
        else
            step_acc = {div_diff[WORD_W-1:0], acc[WORD_W-2:0], 1'b1};
    end

    logic [2*WORD_W-1:0] prod;
    logic [WORD_W-1:0]   quot;
    logic [WORD_W-1:0]   rem;
    logic [WORD_W-1:0]   fix_hi;
    logic [WORD_W-1:0]   fix_lo;

    always_comb begin
        prod   = res_neg ? -acc : acc;
        quot   = res_neg ? -acc[WORD_W-1:0] : acc[WORD_W-1:0];
        rem    = rem_neg ? -acc[2*WORD_W-1:WORD_W]
                         : acc[2*WORD_W-1:WORD_W];
        fix_hi = is_div ? rem  : prod[2*WORD_W-1:WORD_W];
        fix_lo = is_div ? quot : prod[WORD_W-1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_md) state_next = RUN;
            RUN: begin
                if (flush)
                    state_next = IDLE;
                else if (count == CNT_W'(1))
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_md) begin
                        count   <= CNT_W'(WORD_W);
                        is_div  <= op[1];
                        rem_neg <= a_neg;
                        if (op[1]) begin
                            acc     <= {{WORD_W{1'b0}}, a_mag};
                            opnd    <= b_mag;
                            // Divide by zero keeps the all-ones quotient.
                            res_neg <= (a_neg ^ b_neg) & ~b_zero;
                        end else begin
                            acc     <= {{WORD_W{1'b0}}, b_mag};
                            opnd    <= a_mag;
                            res_neg <= a_neg ^ b_neg;
                        end
                    end else if (req_mthi) begin
                        hi <= a;
                    end else if (req_mtlo) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc   <= step_acc;
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit.
// It compares results against an arithmetic reference model.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.WORD_W(32)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_md(input logic [2:0] o,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh,
                                   output logic [31:0] rl);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin
                p  = 64'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd1: begin
                p  = {32'b0, x} * {32'b0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = x;
                end else if (o == 3'd2) begin
                    q  = sx / sy;
                    r  = sx % sy;
                    rl = q[31:0];
                    rh = r[31:0];
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endfunction

    task automatic do_md(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        int k;
        logic seen;
        logic busy_ok;
        @(posedge CLK); #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge CLK); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_accept", 64'(busy), 64'd1);
        k       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && k < 40) begin
            @(posedge CLK); #1;
            k++;
            if (k == 10) begin
                start = 1'b1;
                op    = 3'b100;
            end
            if (k == 11) start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        ref_md(o, x, y, m_hi, m_lo);
        chk($sformatf("latency op%0d", o), 64'(k), 64'd33);
        chk("busy_during_run", 64'(busy_ok), 64'd1);
        chk("busy_with_done", 64'(busy), 64'd0);
        chk($sformatf("hi op%0d %h %h", o, x, y), 64'(hi), 64'(m_hi));
        chk($sformatf("lo op%0d %h %h", o, x, y), 64'(lo), 64'(m_lo));
        @(posedge CLK); #1;
        chk("done_single", 64'(done), 64'd0);
    endtask

    task automatic watch_no_done(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        nRST  = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        #2 nRST = 1'b0;
        #3;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        do_md(3'd0, 32'hFFFF_FFF9, 32'd3);
        chk("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        do_md(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        do_md(3'd3, 32'd7, 32'd2);
        do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
        do_md(3'd3, 32'd5, 32'd0);
        chk("divu_zero_hi", 64'(hi), 64'd5);
        do_md(3'd2, 32'hFFFF_FFF0, 32'd0);

        // MTHI then MTLO on back-to-back cycles
        @(posedge CLK); #1;
        start = 1'b1;
        op    = 3'b100;
        a     = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        op    = 3'b101;
        a     = 32'h1234_5678;
        chk("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
        chk("mthi_busy", 64'(busy), 64'd0);
        @(posedge CLK); #1;
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h0000_0000_1234_5678);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mt_done", 64'(done), 64'd0);
        m_hi = 32'hDEAD_BEEF;
        m_lo = 32'h1234_5678;

        // flush mid-multiply, with an ignored start while busy
        @(posedge CLK); #1;
        start = 1'b1;
        op    = 3'b001;
        a     = 32'd6;
        b     = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        start = 1'b1;
        op    = 3'b100;
        a     = 32'h5555_5555;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        watch_no_done("flush_no_done");
        chk("flush_hi", 64'(hi), 64'(m_hi));
        chk("flush_lo", 64'(lo), 64'(m_lo));

        // flush in IDLE drops an MTHI
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b100;
        a     = 32'hAAAA_AAAA;
        @(posedge CLK); #1;
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_hi", 64'(hi), 64'(m_hi));

        // undefined op is a no-op
        start = 1'b1;
        op    = 3'b110;
        a     = 32'h0BAD_0BAD;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        chk("undef_busy", 64'(busy), 64'd0);
        chk("undef_hi", 64'(hi), 64'(m_hi));
        chk("undef_lo", 64'(lo), 64'(m_lo));

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = '0;
                1: begin
                    rx = 32'h8000_0000;
                    ry = 32'hFFFF_FFFF;
                end
                2: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_md(ro, rx, ry);
        end

        // asynchronous reset in the middle of a divide
        @(posedge CLK); #1;
        start = 1'b1;
        op    = 3'b010;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        watch_no_done("arst_no_done");
        chk("arst_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
